inst_mem_mb: RTL

//  Multi-bank, multi-read-port successor to the single-port instruction memory.
//  - Low-order-interleaved banks; one write port; NUM_RD independent read ports.
//  - Per-bank round-robin arbitration, byte-masked writes, selectable read latency.
//  - Selectable read-during-write policy and a self-clearing init sequence after reset.
//  - Sits between the fetch stage(s) and the program loader.

---
 rtl/inst_mem_pkg.sv | 27 ++
 rtl/inst_mem_bank.sv | 48 ++++
 rtl/inst_mem_mb.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_pkg.sv
// Shared types and address helpers for the banked instruction memory.
package inst_mem_pkg;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam int WR_READ_FIRST  = 0;
    localparam int WR_WRITE_FIRST = 1;

    // nbanks is a power of two, so the low bits pick the bank
    function automatic int unsigned bank_of(
        input int unsigned addr,
        input int unsigned nbanks
    );
        return addr & (nbanks - 1);
    endfunction

    function automatic int unsigned row_of(
        input int unsigned addr,
        input int unsigned lg_banks
    );
        return addr >> lg_banks;
    endfunction

endpackage

// File: rtl/inst_mem_bank.sv
// One 1R1W bank: byte-masked write, registered read,
// optional write-first bypass for same-row read-during-write.
module inst_mem_bank
    import inst_mem_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int RW      = 8,
    parameter int WR_MODE = 0
) (
    input  logic              clk,
    input  logic              we,
    input  logic [RW-1:0]     waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [DWIDTH/8-1:0] wmask,
    input  logic              re,
    input  logic [RW-1:0]     raddr,
    output logic [DWIDTH-1:0] rdata
);

    localparam int ROWS = 2 ** RW;
    localparam int MW   = DWIDTH / 8;

    logic [DWIDTH-1:0] mem [ROWS];
    logic [DWIDTH-1:0] merged;

    always_comb begin
        merged = mem[waddr];
        for (int k = 0; k < MW; k++) begin
            if (wmask[k]) merged[8*k +: 8] = wdata[8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < MW; k++) begin
            if (we && wmask[k]) begin
                mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
        if (re) begin
            if (WR_MODE == WR_WRITE_FIRST && we && waddr == raddr) begin
                rdata <= merged;
            end else begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/inst_mem_mb.sv
// Banked multi-read-port instruction memory: per-bank round-robin
// read arbitration, post-reset clear sequence, RD_LAT output pipeline.
module inst_mem_mb
    import inst_mem_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int ADDR      = 10,
    parameter int NUM_BANKS = 4,
    parameter int NUM_RD    = 2,
    parameter int RD_LAT    = 1,
    parameter int WR_MODE   = 0
) (
    input  logic                     i_mem_clk,
    input  logic                     i_rst_n,
    input  logic                     i_csb,
    input  logic                     i_web,
    input  logic [ADDR-1:0]          i_write_addr,
    input  logic [DWIDTH-1:0]        i_data,
    input  logic [DWIDTH/8-1:0]      i_wmask,
    input  logic [NUM_RD-1:0]        i_rd_req,
    input  logic [NUM_RD*ADDR-1:0]   i_read_addr,
    output logic [NUM_RD-1:0]        o_rd_gnt,
    output logic [NUM_RD-1:0]        o_rd_valid,
    output logic [NUM_RD*DWIDTH-1:0] o_data,
    output logic                     o_init_done
);

    localparam int LG   = $clog2(NUM_BANKS);
    localparam int RW   = (ADDR - LG > 0) ? ADDR - LG : 1;
    localparam int ROWS = (2 ** ADDR) / NUM_BANKS;
    localparam int BW   = (LG > 0) ? LG : 1;
    localparam int PW   = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int MW   = DWIDTH / 8;

    state_t state;
    logic [RW-1:0] cnt;
    logic run;
    logic ext_we;
    logic [BW-1:0] wbank;
    logic [RW-1:0] wrow;

    logic [ADDR-1:0] raddr [NUM_RD];
    logic [BW-1:0] pbank [NUM_RD];
    logic [RW-1:0] prow [NUM_RD];
    logic [NUM_RD-1:0] elig;
    logic [NUM_RD-1:0] gnt;

    logic [PW-1:0] rr [NUM_BANKS];
    logic [PW-1:0] bsel [NUM_BANKS];
    logic [NUM_BANKS-1:0] bact;
    logic [NUM_BANKS-1:0][DWIDTH-1:0] b_rdata;

    assign run    = (state == RUN);
    assign ext_we = run && !i_csb && !i_web;
    assign wbank  = BW'(bank_of(32'(i_write_addr), NUM_BANKS));
    assign wrow   = RW'(row_of(32'(i_write_addr), LG));
    assign elig   = (run && !i_csb) ? i_rd_req : '0;
    assign o_rd_gnt = gnt;

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            raddr[p] = i_read_addr[p*ADDR +: ADDR];
            pbank[p] = BW'(bank_of(32'(raddr[p]), NUM_BANKS));
            prow[p]  = RW'(row_of(32'(raddr[p]), LG));
        end
    end

    // d = distance of port p after the bank's pointer; smallest wins
    always_comb begin
        int d;
        int best;
        d    = 0;
        best = 0;
        bact = '0;
        gnt  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bsel[b] = '0;
            best    = NUM_RD;
            for (int p = 0; p < NUM_RD; p++) begin
                d = p - int'(rr[b]);
                if (d < 0) d = d + NUM_RD;
                if (elig[p] && pbank[p] == BW'(b) && d < best) begin
                    best    = d;
                    bsel[b] = PW'(p);
                    bact[b] = 1'b1;
                end
            end
            for (int p = 0; p < NUM_RD; p++) begin
                if (bact[b] && bsel[b] == PW'(p)) gnt[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_mem_clk) begin
        if (!i_rst_n) begin
            state       <= INIT;
            cnt         <= '0;
            o_init_done <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) rr[b] <= '0;
        end else begin
            unique case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == RW'(ROWS - 1)) begin
                        state       <= RUN;
                        o_init_done <= 1'b1;
                    end
                end
                RUN: ;
            endcase
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (bact[b]) begin
                    if (bsel[b] == PW'(NUM_RD - 1)) rr[b] <= '0;
                    else rr[b] <= bsel[b] + 1'b1;
                end
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic              we;
        logic [RW-1:0]     waddr;
        logic [DWIDTH-1:0] wdata;
        logic [MW-1:0]     wmask;

        // while clearing, every bank writes zero to row cnt
        assign we    = run ? (ext_we && wbank == BW'(b)) : 1'b1;
        assign waddr = run ? wrow : cnt;
        assign wdata = run ? i_data : '0;
        assign wmask = run ? i_wmask : '1;

        inst_mem_bank #(
            .DWIDTH  (DWIDTH),
            .RW      (RW),
            .WR_MODE (WR_MODE)
        ) u_bank (
            .clk   (i_mem_clk),
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .wmask (wmask),
            .re    (bact[b]),
            .raddr (prow[bsel[b]]),
            .rdata (b_rdata[b])
        );
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        logic              v1;
        logic [BW-1:0]     tag1;
        logic              v2;
        logic [DWIDTH-1:0] d2;

        always_ff @(posedge i_mem_clk) begin
            if (!i_rst_n) begin
                v1   <= 1'b0;
                tag1 <= '0;
                v2   <= 1'b0;
                d2   <= '0;
            end else begin
                v1 <= gnt[p];
                if (gnt[p]) tag1 <= pbank[p];
                v2 <= v1;
                if (v1) d2 <= b_rdata[tag1];
            end
        end

        if (RD_LAT == 2) begin : g_lat2
            logic              v3;
            logic [DWIDTH-1:0] d3;

            always_ff @(posedge i_mem_clk) begin
                if (!i_rst_n) begin
                    v3 <= 1'b0;
                    d3 <= '0;
                end else begin
                    v3 <= v2;
                    if (v2) d3 <= d2;
                end
            end

            assign o_rd_valid[p] = v3;
            assign o_data[p*DWIDTH +: DWIDTH] = d3;
        end else begin : g_lat1
            assign o_rd_valid[p] = v2;
            assign o_data[p*DWIDTH +: DWIDTH] = d2;
        end
    end

endmodule
